calc_hist: RTL and testbench

- Parametrised successor of the 16-bit button calculator.
- Holds a WIDTH-bit accumulator and applies one ALU operation per press of btnd, using operand sw and an opcode chosen by {btnl,btnc,btnr}.
- New over the previous generation:
  - rising-edge detection on the buttons;
  - a signed-overflow flag;
  - a DEPTH-entry circular undo history, stepped back by btnz.
- Sits between the board buttons/switches and the LED bank.

---
 rtl/calc_hist.sv | 82 ++++++++
 tb/tb_calc_hist.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_hist.sv
// calc_hist: button calculator with edge-detected execute, signed overflow flag and circular undo history
// Ports: clk; btnu sync active-high reset; btnd execute; btnz undo; {btnl,btnc,btnr} opcode;
//        sw operand B; led accumulator; ovf ADD/SUB signed overflow; empty no history; hist_cnt valid entries
module calc_hist #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         btnu,
  input  logic                         btnd,
  input  logic                         btnz,
  input  logic                         btnl,
  input  logic                         btnc,
  input  logic                         btnr,
  input  logic [WIDTH-1:0]             sw,
  output logic [WIDTH-1:0]             led,
  output logic                         ovf,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt
);
  localparam int SW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] acc_q, acc_d, res, sum, diff, asr;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, wp_inc, wp_dec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, ovf_res, btnd_q, btnz_q, exec, undo, do_undo, add_ov, sub_ov, lt;
  logic [2:0]       op;
  logic [SW-1:0]    sh;
  always_comb begin
    op      = {btnl, btnc, btnr};
    sh      = sw[SW-1:0];
    exec    = btnd & ~btnd_q;
    undo    = btnz & ~btnz_q;
    sum     = acc_q + sw;
    diff    = acc_q - sw;
    asr     = $signed(acc_q) >>> sh;
    lt      = $signed(acc_q) < $signed(sw);
    add_ov  = (acc_q[WIDTH-1] == sw[WIDTH-1]) & (sum[WIDTH-1] != acc_q[WIDTH-1]);
    sub_ov  = (acc_q[WIDTH-1] != sw[WIDTH-1]) & (diff[WIDTH-1] != acc_q[WIDTH-1]);
    res     = op == 3'd0 ? acc_q & sw :
              op == 3'd1 ? acc_q | sw :
              op == 3'd2 ? sum :
              op == 3'd3 ? diff :
              op == 3'd4 ? WIDTH'(lt) :
              op == 3'd5 ? acc_q << sh :
              op == 3'd6 ? asr : acc_q ^ sw;
    ovf_res = op == 3'd2 ? add_ov : op == 3'd3 ? sub_ov : 1'b0;
    wp_inc  = wp_q == PW'(DEPTH-1) ? '0 : wp_q + PW'(1);
    wp_dec  = wp_q == '0 ? PW'(DEPTH-1) : wp_q - PW'(1);
    // exec wins a same-cycle collision; the undo edge is simply dropped
    do_undo = undo & ~exec & (cnt_q != '0);
    acc_d   = exec ? res : do_undo ? hist_q[wp_dec] : acc_q;
    ovf_d   = exec ? ovf_res : do_undo ? 1'b0 : ovf_q;
    wp_d    = exec ? wp_inc : do_undo ? wp_dec : wp_q;
    cnt_d   = exec ? (cnt_q == CW'(DEPTH) ? cnt_q : cnt_q + CW'(1)) :
              do_undo ? cnt_q - CW'(1) : cnt_q;
  end
  // edge registers load the raw buttons during reset so a held button cannot fire on release
  always_ff @(posedge clk) begin
    btnd_q <= btnd;
    btnz_q <= btnz;
    if (btnu) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (!btnu && exec) hist_q[wp_q] <= acc_q;
  assign led      = acc_q;
  assign ovf      = ovf_q;
  assign hist_cnt = cnt_q;
  assign empty    = cnt_q == '0;
endmodule

// File: tb/tb_calc_hist.sv
// tb_calc_hist: directed self-checking bench for calc_hist (WIDTH=16, DEPTH=4)
module tb_calc_hist;
  logic clk = 1'b0, btnu = 1'b0, btnd = 1'b0, btnz = 1'b0, btnl = 1'b0, btnc = 1'b0, btnr = 1'b0;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic ovf, empty;
  logic [2:0] hist_cnt;
  int errs = 0, checks = 0;
  calc_hist #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .btnu(btnu), .btnd(btnd), .btnz(btnz), .btnl(btnl), .btnc(btnc), .btnr(btnr),
    .sw(sw), .led(led), .ovf(ovf), .empty(empty), .hist_cnt(hist_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [2:0] op, input logic [15:0] b);
    {btnl, btnc, btnr} = op;
    sw = b;
    btnd = 1'b1;
    tick();
    btnd = 1'b0;
    tick();
  endtask
  task automatic unpress();
    btnz = 1'b1;
    tick();
    btnz = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (led !== 16'h0 || ovf !== 1'b0 || hist_cnt !== 3'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL reset: led=%h ovf=%b cnt=%0d empty=%b, want 0000 0 0 1", led, ovf, hist_cnt, empty);
    end
  endtask
  logic [2:0]  t_op  [9] = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd7, 3'd2, 3'd5, 3'd6, 3'd4};
  logic [15:0] t_b   [9] = '{16'h354A, 16'h1234, 16'h1001, 16'hF0F0, 16'h1FA2, 16'h6AA2, 16'h0004, 16'h0001, 16'h46FF};
  logic [15:0] t_led [9] = '{16'h354A, 16'h2316, 16'h3317, 16'h3010, 16'h2FB2, 16'h9A54, 16'hA540, 16'hD2A0, 16'h0001};
  logic        t_ovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  t_cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
  task automatic test_ops();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(t_op[i], t_b[i]);
      checks++;
      if (led !== t_led[i] || ovf !== t_ovf[i] || hist_cnt !== t_cnt[i]) begin
        errs++;
        $display("FAIL op%0d: led=%h ovf=%b cnt=%0d, want %h %b %0d", i, led, ovf, hist_cnt, t_led[i], t_ovf[i], t_cnt[i]);
      end
    end
  endtask
  task automatic test_undo();
    logic [15:0] exp [4] = '{16'h2FB2, 16'h3010, 16'h3317, 16'h2316};
    do_reset();
    for (int i = 0; i < 6; i++) press(t_op[i], t_b[i]);
    for (int i = 0; i < 4; i++) begin
      unpress();
      checks++;
      if (led !== exp[i] || hist_cnt !== 3'(3 - i) || ovf !== 1'b0 || empty !== (i == 3)) begin
        errs++;
        $display("FAIL undo%0d: led=%h cnt=%0d ovf=%b empty=%b, want %h %0d 0 %b", i, led, hist_cnt, ovf, empty, exp[i], 3 - i, i == 3);
      end
    end
    unpress();
    checks++;
    if (led !== 16'h2316 || hist_cnt !== 3'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL undo_empty: led=%h cnt=%0d empty=%b, want 2316 0 1", led, hist_cnt, empty);
    end
  endtask
  task automatic test_held();
    do_reset();
    {btnl, btnc, btnr} = 3'd2;
    sw = 16'h0001;
    btnd = 1'b1;
    repeat (5) tick();
    btnd = 1'b0;
    tick();
    checks++;
    if (led !== 16'h0001 || hist_cnt !== 3'd1) begin
      errs++;
      $display("FAIL held_exec: led=%h cnt=%0d, want 0001 1", led, hist_cnt);
    end
    btnz = 1'b1;
    repeat (5) tick();
    btnz = 1'b0;
    tick();
    checks++;
    if (led !== 16'h0000 || hist_cnt !== 3'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL held_undo: led=%h cnt=%0d empty=%b, want 0000 0 1", led, hist_cnt, empty);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    press(3'd2, 16'h0003);
    {btnl, btnc, btnr} = 3'd2;
    sw = 16'h0005;
    btnd = 1'b1;
    btnz = 1'b1;
    tick();
    btnd = 1'b0;
    btnz = 1'b0;
    repeat (2) tick();
    checks++;
    if (led !== 16'h0008 || hist_cnt !== 3'd2) begin
      errs++;
      $display("FAIL simultaneous: led=%h cnt=%0d, want 0008 2", led, hist_cnt);
    end
    unpress();
    checks++;
    if (led !== 16'h0003 || hist_cnt !== 3'd1) begin
      errs++;
      $display("FAIL simul_undo: led=%h cnt=%0d, want 0003 1", led, hist_cnt);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    press(3'd2, 16'h0000);
    press(3'd2, 16'h0001);
    press(3'd2, 16'h7FFF);
    checks++;
    if (led !== 16'h8000 || ovf !== 1'b1 || hist_cnt !== 3'd3) begin
      errs++;
      $display("FAIL mid_setup: led=%h ovf=%b cnt=%0d, want 8000 1 3", led, ovf, hist_cnt);
    end
    {btnl, btnc, btnr} = 3'd2;
    sw = 16'h0001;
    btnd = 1'b1;
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
    checks++;
    if (led !== 16'h0 || ovf !== 1'b0 || hist_cnt !== 3'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset: led=%h ovf=%b cnt=%0d empty=%b, want 0000 0 0 1", led, ovf, hist_cnt, empty);
    end
    repeat (3) tick();
    checks++;
    if (led !== 16'h0 || hist_cnt !== 3'd0) begin
      errs++;
      $display("FAIL mid_release: led=%h cnt=%0d, want 0000 0", led, hist_cnt);
    end
    btnd = 1'b0;
    tick();
    press(3'd2, 16'h0001);
    checks++;
    if (led !== 16'h0001 || hist_cnt !== 3'd1) begin
      errs++;
      $display("FAIL mid_repress: led=%h cnt=%0d, want 0001 1", led, hist_cnt);
    end
  endtask
  task automatic test_ovf_sub();
    do_reset();
    press(3'd2, 16'h8000);
    checks++;
    if (led !== 16'h8000 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL sub_setup: led=%h ovf=%b, want 8000 0", led, ovf);
    end
    press(3'd3, 16'h0001);
    checks++;
    if (led !== 16'h7FFF || ovf !== 1'b1 || hist_cnt !== 3'd2) begin
      errs++;
      $display("FAIL sub_ovf: led=%h ovf=%b cnt=%0d, want 7fff 1 2", led, ovf, hist_cnt);
    end
    {btnl, btnc, btnr} = 3'd7;
    sw = 16'hFFFF;
    repeat (3) tick();
    checks++;
    if (led !== 16'h7FFF || ovf !== 1'b1 || hist_cnt !== 3'd2) begin
      errs++;
      $display("FAIL no_edge: led=%h ovf=%b cnt=%0d, want 7fff 1 2", led, ovf, hist_cnt);
    end
    unpress();
    checks++;
    if (led !== 16'h8000 || ovf !== 1'b0 || hist_cnt !== 3'd1) begin
      errs++;
      $display("FAIL sub_undo: led=%h ovf=%b cnt=%0d, want 8000 0 1", led, ovf, hist_cnt);
    end
  endtask
  initial begin
    tick();
    test_reset();
    test_ops();
    test_undo();
    test_held();
    test_back_to_back();
    test_reset_mid();
    test_ovf_sub();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
